// File: rtl/vc_mem_responder_1port.sv
// Single-port memory responder for the VC val/rdy memory protocol: byte-addressed
// array, fixed accept-to-response latency, in-order buffered responses.
module vc_mem_responder_1port #(
   parameter int p_mem_sz  = 1 << 16,
   parameter int p_addr_sz = 32,
   parameter int p_data_sz = 32,
   parameter int p_latency = 2,
   parameter int p_depth   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           memreq_val,
   output logic                           memreq_rdy,
   input  logic [p_addr_sz+p_data_sz+2:0] memreq_msg,
   output logic                           memresp_val,
   input  logic                           memresp_rdy,
   output logic [p_data_sz+2:0]           memresp_msg,
   output logic [2:0]                     outstanding
);

   localparam int         c_words = p_mem_sz / 4;
   localparam int         c_idx_w = $clog2(p_mem_sz) - 2;
   localparam logic [2:0] c_depth = 3'(p_depth);
   localparam logic [2:0] c_last  = 3'(p_depth - 1);
   localparam logic [2:0] c_lat   = 3'(p_latency - 1);

   // Handshakes: a transfer happens on a posedge where val && rdy are both high;
   // memreq_rdy depends only on registered state, and a raised memresp_val keeps
   // memresp_msg stable until the consumer takes it.
   logic                 w_type;
   logic [p_addr_sz-1:0] w_addr;
   logic [1:0]           w_len;
   logic [p_data_sz-1:0] w_data;
   logic [c_idx_w-1:0]   w_idx;
   logic [1:0]           w_lane;
   logic [31:0]          w_rd_word;
   logic [31:0]          w_rd_data;
   logic [31:0]          w_wdata;
   logic [3:0]           w_be;
   logic                 w_req_fire;
   logic                 w_resp_fire;
   logic                 w_unused_addr;

   assign w_type        = memreq_msg[p_addr_sz+p_data_sz+2];
   assign w_addr        = memreq_msg[p_addr_sz+p_data_sz+1:p_data_sz+2];
   assign w_len         = memreq_msg[p_data_sz+1:p_data_sz];
   assign w_data        = memreq_msg[p_data_sz-1:0];
   assign w_idx         = w_addr[c_idx_w+1:2];
   assign w_lane        = w_addr[1:0];
   assign w_unused_addr = ^w_addr;

   logic [31:0] r_mem [c_words];
   assign w_rd_word = r_mem[w_idx];

   // len 1 = byte, 2 = halfword, anything else (including reserved 3) = word.
   always_comb begin
      w_be      = 4'b1111;
      w_wdata   = w_data;
      w_rd_data = w_rd_word;
      case (w_len)
         2'd1: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{w_data[7:0]}};
            case (w_lane)
               2'd0:    w_rd_data = {24'd0, w_rd_word[7:0]};
               2'd1:    w_rd_data = {24'd0, w_rd_word[15:8]};
               2'd2:    w_rd_data = {24'd0, w_rd_word[23:16]};
               default: w_rd_data = {24'd0, w_rd_word[31:24]};
            endcase
         end
         2'd2: begin
            w_be      = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {2{w_data[15:0]}};
            w_rd_data = w_addr[1] ? {16'd0, w_rd_word[31:16]} : {16'd0, w_rd_word[15:0]};
         end
         default: ;
      endcase
   end

   logic       r_en;
   logic [2:0] r_wr;
   logic [2:0] r_rd;
   logic [2:0] r_cnt;
   logic       r_type [8];
   logic [1:0] r_len  [8];
   logic [31:0] r_data [8];
   logic [2:0] r_age  [8];

   assign memreq_rdy  = r_en && (r_cnt < c_depth);
   assign memresp_val = (r_cnt != 3'd0) && (r_age[r_rd] >= c_lat);
   assign memresp_msg = {r_type[r_rd], r_len[r_rd], r_data[r_rd]};
   assign outstanding = r_cnt;
   assign w_req_fire  = memreq_val && memreq_rdy;
   assign w_resp_fire = memresp_val && memresp_rdy;

   always_ff @(posedge clk) begin
      if (reset && w_req_fire && w_type) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_en  <= 1'b0;
         r_wr  <= 3'd0;
         r_rd  <= 3'd0;
         r_cnt <= 3'd0;
      end else begin
         r_en <= 1'b1;
         if (w_req_fire)  r_wr <= (r_wr == c_last) ? 3'd0 : r_wr + 3'd1;
         if (w_resp_fire) r_rd <= (r_rd == c_last) ? 3'd0 : r_rd + 3'd1;
         if (w_req_fire && !w_resp_fire)      r_cnt <= r_cnt + 3'd1;
         else if (!w_req_fire && w_resp_fire) r_cnt <= r_cnt - 3'd1;
      end
   end

   // Each slot ages from its accept edge and saturates once the response is eligible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (w_req_fire && (r_wr == 3'(i))) begin
            r_type[i] <= w_type;
            r_len[i]  <= w_len;
            r_data[i] <= w_type ? 32'd0 : w_rd_data;
            r_age[i]  <= 3'd0;
         end else if (r_age[i] < c_lat) begin
            r_age[i] <= r_age[i] + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_vc_mem_responder_1port.sv
// Self-checking bench for vc_mem_responder_1port: scenario tasks plus a
// negedge scoreboard driven by a byte-array reference model.
module tb_vc_mem_responder_1port;

   localparam int L = 2;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memreq_val;
   logic        memreq_rdy;
   logic [66:0] memreq_msg;
   logic        memresp_val;
   logic        memresp_rdy;
   logic [34:0] memresp_msg;
   logic [2:0]  outstanding;

   int n_checks = 0;
   int n_fail   = 0;

   vc_mem_responder_1port #(.p_latency(L), .p_depth(D)) dut (
      .clk(clk), .reset(reset),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
      .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   // ---------------- reference model + scoreboard ----------------
   logic [7:0]  mem_m [65536];
   logic [34:0] exp_q [$];
   int          edge_q [$];
   int          cnt_m    = 0;
   int          cyc      = 0;
   logic        last_rst = 1'b0;
   logic        mon_en   = 1'b0;

   function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] len);
      int a;
      a = int'(addr[15:0]);
      if (len == 2'd1) return {24'd0, mem_m[a]};
      if (len == 2'd2) begin
         a = a & 32'hfffe;
         return {16'd0, mem_m[a+1], mem_m[a]};
      end
      a = a & 32'hfffc;
      return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] d);
      int a;
      a = int'(addr[15:0]);
      if (len == 2'd1) mem_m[a] = d[7:0];
      else if (len == 2'd2) begin
         a = a & 32'hfffe;
         mem_m[a] = d[7:0]; mem_m[a+1] = d[15:8];
      end else begin
         a = a & 32'hfffc;
         mem_m[a] = d[7:0]; mem_m[a+1] = d[15:8]; mem_m[a+2] = d[23:16]; mem_m[a+3] = d[31:24];
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem_m[i] = 8'h00;
   end

   always @(negedge clk) begin
      logic exp_rdy, exp_val;
      exp_rdy = last_rst && (cnt_m < D);
      exp_val = last_rst && (exp_q.size() > 0) && (edge_q.size() > 0) && (cyc >= edge_q[0] + L);
      if (mon_en) begin
         n_checks++;
         if (memreq_rdy !== exp_rdy) begin
            n_fail++; $display("FAIL sb_req_rdy cyc=%0d got=%b exp=%b", cyc, memreq_rdy, exp_rdy);
         end
         n_checks++;
         if (memresp_val !== exp_val) begin
            n_fail++; $display("FAIL sb_resp_val cyc=%0d got=%b exp=%b", cyc, memresp_val, exp_val);
         end
         n_checks++;
         if (outstanding !== 3'(cnt_m)) begin
            n_fail++; $display("FAIL sb_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding, cnt_m);
         end
         if (exp_val) begin
            n_checks++;
            if (memresp_msg !== exp_q[0]) begin
               n_fail++; $display("FAIL sb_resp_msg cyc=%0d got=%h exp=%h", cyc, memresp_msg, exp_q[0]);
            end
         end
      end
      if (reset !== 1'b1) begin
         exp_q.delete(); edge_q.delete(); cnt_m = 0;
      end else begin
         if (exp_val && memresp_rdy) begin
            void'(exp_q.pop_front()); void'(edge_q.pop_front()); cnt_m--;
         end
         if (memreq_val && exp_rdy) begin
            if (memreq_msg[66]) begin
               model_write(memreq_msg[65:34], memreq_msg[33:32], memreq_msg[31:0]);
               exp_q.push_back({1'b1, memreq_msg[33:32], 32'd0});
            end else begin
               exp_q.push_back({1'b0, memreq_msg[33:32], model_read(memreq_msg[65:34], memreq_msg[33:32])});
            end
            edge_q.push_back(cyc);
            cnt_m++;
         end
      end
      last_rst = reset;
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic t, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
      int   waits;
      logic acc;
      waits = 0;
      memreq_val = 1'b1;
      memreq_msg = {t, a, l, d};
      do begin
         acc = memreq_rdy;
         @(posedge clk); #1;
         waits++;
      end while (!acc && waits < 50);
      memreq_val = 1'b0;
      if (!acc) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout got=no_accept exp=accept");
      end
   endtask

   task automatic wait_resp(output logic [34:0] m);
      int   waits;
      logic v;
      waits = 0;
      do begin
         v = memresp_val;
         m = memresp_msg;
         @(posedge clk); #1;
         waits++;
      end while (!v && waits < 50);
      if (!v) begin
         n_checks++; n_fail++;
         $display("FAIL resp_timeout got=no_resp exp=resp");
      end
   endtask

   task automatic drain();
      memresp_rdy = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0; memreq_val = 1'b1; memreq_msg = '0; memresp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         mon_en = 1'b1;
         n_checks++;
         if ({memreq_rdy, memresp_val, outstanding} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state got=rdy%b val%b out%0d exp=0/0/0", memreq_rdy, memresp_val, outstanding);
         end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (memreq_rdy !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_rdy got=%b exp=1", memreq_rdy);
      end
      memreq_val = 1'b0;
      memresp_rdy = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (outstanding !== 3'd0) begin
         n_fail++; $display("FAIL reset_no_accept got=%0d exp=0", outstanding);
      end
   endtask

   task automatic test_fill();
      memresp_rdy = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] a;
         a = 32'(i * 4) | ($urandom_range(0, 7) << 16);
         send(1'b1, a, 2'd0, $urandom);
      end
      drain();
   endtask

   task automatic test_write_read();
      memresp_rdy = 1'b1;
      send(1'b1, 32'h100, 2'd0, 32'hdeadbeef);
      send(1'b0, 32'h100, 2'd0, 32'h0);
      n_checks++;
      if (memresp_val !== 1'b1 || memresp_msg !== {1'b1, 2'd0, 32'd0}) begin
         n_fail++; $display("FAIL wr_resp_latency got=%b/%h exp=1/%h", memresp_val, memresp_msg, {1'b1, 2'd0, 32'd0});
      end
      @(posedge clk); #1;
      n_checks++;
      if (memresp_val !== 1'b1 || memresp_msg !== {1'b0, 2'd0, 32'hdeadbeef}) begin
         n_fail++; $display("FAIL rd_resp_latency got=%b/%h exp=1/%h", memresp_val, memresp_msg, {1'b0, 2'd0, 32'hdeadbeef});
      end
      drain();
   endtask

   task automatic test_subword();
      logic [34:0] m;
      logic [31:0] exp_d [4];
      logic [31:0] a_t [4];
      logic [1:0]  l_t [4];
      exp_d[0] = 32'haa223344; a_t[0] = 32'h100;     l_t[0] = 2'd0;
      exp_d[1] = 32'h000000aa; a_t[1] = 32'h103;     l_t[1] = 2'd1;
      exp_d[2] = 32'h0000aa22; a_t[2] = 32'h102;     l_t[2] = 2'd2;
      exp_d[3] = 32'h0000aa22; a_t[3] = 32'h30103;   l_t[3] = 2'd2;
      memresp_rdy = 1'b1;
      send(1'b1, 32'h100, 2'd0, 32'h11223344); wait_resp(m);
      send(1'b1, 32'h103, 2'd1, 32'hffffffaa); wait_resp(m);
      n_checks++;
      if (m !== {1'b1, 2'd1, 32'd0}) begin
         n_fail++; $display("FAIL byte_wr_resp got=%h exp=%h", m, {1'b1, 2'd1, 32'd0});
      end
      for (int i = 0; i < 4; i++) begin
         send(1'b0, a_t[i], l_t[i], 32'h0); wait_resp(m);
         n_checks++;
         if (m !== {1'b0, l_t[i], exp_d[i]}) begin
            n_fail++; $display("FAIL subword_rd%0d got=%h exp=%h", i, m, {1'b0, l_t[i], exp_d[i]});
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      int          n_acc;
      logic [34:0] m0, m;
      n_acc = 0;
      memresp_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         memreq_val = 1'b1;
         memreq_msg = {1'b0, 32'(i * 4), 2'd0, 32'd0};
         if (memreq_rdy) n_acc++;
         @(posedge clk); #1;
      end
      memreq_val = 1'b0;
      n_checks++;
      if (n_acc != 4 || memreq_rdy !== 1'b0 || outstanding !== 3'd4) begin
         n_fail++; $display("FAIL bp_full got=acc%0d rdy%b out%0d exp=acc4 rdy0 out4", n_acc, memreq_rdy, outstanding);
      end
      m0 = memresp_msg;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (memresp_msg !== m0 || memresp_val !== 1'b1) begin
         n_fail++; $display("FAIL bp_stable got=%h exp=%h", memresp_msg, m0);
      end
      memresp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_resp(m);
         n_checks++;
         if (m !== {1'b0, 2'd0, model_read(32'(i * 4), 2'd0)}) begin
            n_fail++; $display("FAIL bp_order%0d got=%h exp=%h", i, m, {1'b0, 2'd0, model_read(32'(i * 4), 2'd0)});
         end
      end
      n_checks++;
      if (memreq_rdy !== 1'b1) begin
         n_fail++; $display("FAIL bp_rdy_back got=%b exp=1", memreq_rdy);
      end
      drain();
   endtask

   task automatic test_simultaneous();
      memresp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b0, 32'(i * 8), 2'd0, 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      memreq_val = 1'b1; memreq_msg = {1'b0, 32'h40, 2'd0, 32'd0}; memresp_rdy = 1'b1;
      @(posedge clk); #1;
      memreq_val = 1'b0; memresp_rdy = 1'b0;
      n_checks++;
      if (outstanding !== 3'd3) begin
         n_fail++; $display("FAIL simul_fire got=%0d exp=3", outstanding);
      end
      drain();
      n_checks++;
      if (outstanding !== 3'd0) begin
         n_fail++; $display("FAIL simul_drain got=%0d exp=0", outstanding);
      end
   endtask

   task automatic test_stream();
      int stalls, got, edges;
      stalls = 0; got = 0; edges = 0;
      memresp_rdy = 1'b1;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               memreq_val = 1'b1;
               memreq_msg = {1'b0, 32'($urandom_range(0, 1023)) | ($urandom_range(0, 3) << 16),
                             2'($urandom_range(0, 3)), 32'd0};
               if (!memreq_rdy) stalls++;
               @(posedge clk); #1;
            end
            memreq_val = 1'b0;
         end
         begin
            while (got < 100 && edges < 300) begin
               logic v;
               v = memresp_val && memresp_rdy;
               @(posedge clk); #1;
               edges++;
               if (v) got++;
            end
         end
      join
      n_checks++;
      if (stalls != 0 || got != 100 || edges != 100 + L) begin
         n_fail++; $display("FAIL stream got=stall%0d resp%0d cyc%0d exp=stall0 resp100 cyc%0d", stalls, got, edges, 100 + L);
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      logic [34:0] m;
      memresp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b0, 32'h100, 2'd0, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({memreq_rdy, memresp_val, outstanding} !== 5'b0) begin
         n_fail++; $display("FAIL midrst_state got=rdy%b val%b out%0d exp=0/0/0", memreq_rdy, memresp_val, outstanding);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      memresp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (memresp_val !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stale%0d got=%b exp=0", i, memresp_val);
         end
         @(posedge clk); #1;
      end
      send(1'b0, 32'h100, 2'd0, 32'd0); wait_resp(m);
      n_checks++;
      if (m !== {1'b0, 2'd0, 32'haa223344}) begin
         n_fail++; $display("FAIL midrst_data got=%h exp=%h", m, {1'b0, 2'd0, 32'haa223344});
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_write_read();
      test_subword();
      test_backpressure();
      test_simultaneous();
      test_stream();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
